// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Purpose  : Encodes RV32I instructions from a decoded request (class, funct3,
//            alt bit, register indices, immediate) into 32-bit machine words.
//            Encoded words go through a 2-entry output FIFO with a
//            valid/ready handshake on each side. Illegal requests are dropped
//            and reported with a one-cycle o_illegal pulse.
// Ports    : i_clk, i_reset (async, active-high)
//            i_req_vld / o_req_rdy          request handshake
//            i_kind, i_funct3, i_alt,
//            i_rd, i_rs1, i_rs2, i_imm      request fields
//            o_instr / o_instr_vld /
//            i_instr_rdy                    output handshake (queue head)
//            o_illegal                      rejected-request pulse
//            o_count                        words handed downstream (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req_vld,
  output logic             o_req_rdy,
  input  logic [3:0]       i_kind,
  input  logic [2:0]       i_funct3,
  input  logic             i_alt,
  input  logic [4:0]       i_rd,
  input  logic [4:0]       i_rs1,
  input  logic [4:0]       i_rs2,
  input  logic [31:0]      i_imm,
  output logic [31:0]      o_instr,
  output logic             o_instr_vld,
  input  logic             i_instr_rdy,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_count
);

  // Request classes
  localparam logic [3:0] c_KIND_R     = 4'd0;
  localparam logic [3:0] c_KIND_I     = 4'd1;
  localparam logic [3:0] c_KIND_S     = 4'd2;
  localparam logic [3:0] c_KIND_L     = 4'd3;
  localparam logic [3:0] c_KIND_B     = 4'd4;
  localparam logic [3:0] c_KIND_LUI   = 4'd5;
  localparam logic [3:0] c_KIND_AUIPC = 4'd6;
  localparam logic [3:0] c_KIND_JAL   = 4'd7;
  localparam logic [3:0] c_KIND_JALR  = 4'd8;

  // Major opcodes
  localparam logic [6:0] c_OP_R     = 7'b0110011;
  localparam logic [6:0] c_OP_I     = 7'b0010011;
  localparam logic [6:0] c_OP_S     = 7'b0100011;
  localparam logic [6:0] c_OP_L     = 7'b0000011;
  localparam logic [6:0] c_OP_B     = 7'b1100011;
  localparam logic [6:0] c_OP_LUI   = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC = 7'b0010111;
  localparam logic [6:0] c_OP_JAL   = 7'b1101111;
  localparam logic [6:0] c_OP_JALR  = 7'b1100111;

  logic [31:0]      w_word;
  logic             w_legal;
  logic             w_push;
  logic             w_pop;
  logic             w_reject;
  logic [1:0]       w_occ_nxt;

  logic [31:0]      r_mem [0:1];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_occ;
  logic             r_illegal;
  logic [CNT_W-1:0] r_count;

  // --------------------------------------------------------------------------
  // Encoder: field placement and legality check for the presented request
  // --------------------------------------------------------------------------
  always_comb begin
    w_word  = 32'h0;
    w_legal = 1'b1;
    case (i_kind)
      c_KIND_R: begin
        // Only ADD/SUB (000) and SRL/SRA (101) have an alternate form
        w_legal = !i_alt || (i_funct3 == 3'b000) || (i_funct3 == 3'b101);
        w_word  = {1'b0, i_alt, 5'b0, i_rs2, i_rs1, i_funct3, i_rd, c_OP_R};
      end
      c_KIND_I: begin
        // SRAI is the only immediate op with an alternate form
        w_legal = !i_alt || (i_funct3 == 3'b101);
        if ((i_funct3 == 3'b001) || (i_funct3 == 3'b101)) begin
          // Shifts: shamt in [24:20], upper immediate bits replaced by funct7
          w_word = {1'b0, i_alt, 5'b0, i_imm[4:0], i_rs1, i_funct3, i_rd, c_OP_I};
        end else begin
          w_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, c_OP_I};
        end
      end
      c_KIND_S: begin
        w_legal = (i_funct3 <= 3'b010);
        w_word  = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], c_OP_S};
      end
      c_KIND_L: begin
        w_legal = !((i_funct3 == 3'b011) || (i_funct3 == 3'b110) || (i_funct3 == 3'b111));
        w_word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, c_OP_L};
      end
      c_KIND_B: begin
        // Branch offsets are halfword aligned; bit 0 is not encodable
        w_legal = !((i_funct3 == 3'b010) || (i_funct3 == 3'b011)) && !i_imm[0];
        w_word  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                   i_imm[4:1], i_imm[11], c_OP_B};
      end
      c_KIND_LUI: begin
        w_word = {i_imm[31:12], i_rd, c_OP_LUI};
      end
      c_KIND_AUIPC: begin
        w_word = {i_imm[31:12], i_rd, c_OP_AUIPC};
      end
      c_KIND_JAL: begin
        w_legal = !i_imm[0];
        w_word  = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, c_OP_JAL};
      end
      c_KIND_JALR: begin
        w_legal = (i_funct3 == 3'b000);
        w_word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, c_OP_JALR};
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // 2-entry output FIFO
  // --------------------------------------------------------------------------
  assign o_req_rdy   = (r_occ != 2'd2);
  assign o_instr_vld = (r_occ != 2'd0);
  assign o_instr     = o_instr_vld ? r_mem[r_rd_ptr] : 32'h0;
  assign o_illegal   = r_illegal;
  assign o_count     = r_count;

  assign w_push   = i_req_vld & o_req_rdy & w_legal;
  assign w_reject = i_req_vld & o_req_rdy & ~w_legal;
  assign w_pop    = o_instr_vld & i_instr_rdy;

  always_comb begin
    w_occ_nxt = r_occ;
    case ({w_push, w_pop})
      2'b10:   w_occ_nxt = r_occ + 2'd1;
      2'b01:   w_occ_nxt = r_occ - 2'd1;
      default: w_occ_nxt = r_occ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mem[0]  <= 32'h0;
      r_mem[1]  <= 32'h0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_occ     <= 2'd0;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_word;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
        r_count  <= r_count + CNT_W'(1);
      end
      r_occ     <= w_occ_nxt;
      r_illegal <= w_reject;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Purpose  : Self-checking bench for instr_encoder. A second instance with a
//            2-bit counter shares all inputs to exercise counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

  typedef struct {
    logic [3:0]  k;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic [3:0]  kind = '0;
  logic [2:0]  funct3 = '0;
  logic        alt = 1'b0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [31:0] imm = '0;
  logic [31:0] instr;
  logic        instr_vld;
  logic        instr_rdy = 1'b0;
  logic        illegal;
  logic [15:0] count;

  logic        req_rdy_w;
  logic [31:0] instr_w;
  logic        instr_vld_w;
  logic        illegal_w;
  logic [1:0]  count_w;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp_count = '0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .i_clk(clk), .i_reset(rst), .i_req_vld(req_vld), .o_req_rdy(req_rdy),
    .i_kind(kind), .i_funct3(funct3), .i_alt(alt), .i_rd(rd), .i_rs1(rs1),
    .i_rs2(rs2), .i_imm(imm), .o_instr(instr), .o_instr_vld(instr_vld),
    .i_instr_rdy(instr_rdy), .o_illegal(illegal), .o_count(count)
  );

  instr_encoder #(.CNT_W(2)) dut_w (
    .i_clk(clk), .i_reset(rst), .i_req_vld(req_vld), .o_req_rdy(req_rdy_w),
    .i_kind(kind), .i_funct3(funct3), .i_alt(alt), .i_rd(rd), .i_rs1(rs1),
    .i_rs2(rs2), .i_imm(imm), .o_instr(instr_w), .o_instr_vld(instr_vld_w),
    .i_instr_rdy(instr_rdy), .o_illegal(illegal_w), .o_count(count_w)
  );

  // Reference encoder built field-by-field from the RV32I format tables
  function automatic logic [31:0] model(input req_t r);
    logic [31:0] w;
    w = 32'h0;
    case (r.k)
      4'd0: begin
        w[6:0] = 7'b0110011; w[11:7] = r.rd; w[14:12] = r.f3;
        w[19:15] = r.rs1; w[24:20] = r.rs2; w[30] = r.alt;
      end
      4'd1: begin
        w[6:0] = 7'b0010011; w[11:7] = r.rd; w[14:12] = r.f3; w[19:15] = r.rs1;
        if (r.f3 == 3'b001 || r.f3 == 3'b101) begin
          w[24:20] = r.imm[4:0]; w[30] = r.alt;
        end else begin
          w[31:20] = r.imm[11:0];
        end
      end
      4'd2: begin
        w[6:0] = 7'b0100011; w[11:7] = r.imm[4:0]; w[14:12] = r.f3;
        w[19:15] = r.rs1; w[24:20] = r.rs2; w[31:25] = r.imm[11:5];
      end
      4'd3: begin
        w[6:0] = 7'b0000011; w[11:7] = r.rd; w[14:12] = r.f3;
        w[19:15] = r.rs1; w[31:20] = r.imm[11:0];
      end
      4'd4: begin
        w[6:0] = 7'b1100011; w[7] = r.imm[11]; w[11:8] = r.imm[4:1];
        w[14:12] = r.f3; w[19:15] = r.rs1; w[24:20] = r.rs2;
        w[30:25] = r.imm[10:5]; w[31] = r.imm[12];
      end
      4'd5: begin w[6:0] = 7'b0110111; w[11:7] = r.rd; w[31:12] = r.imm[31:12]; end
      4'd6: begin w[6:0] = 7'b0010111; w[11:7] = r.rd; w[31:12] = r.imm[31:12]; end
      4'd7: begin
        w[6:0] = 7'b1101111; w[11:7] = r.rd; w[19:12] = r.imm[19:12];
        w[20] = r.imm[11]; w[30:21] = r.imm[10:1]; w[31] = r.imm[20];
      end
      4'd8: begin
        w[6:0] = 7'b1100111; w[11:7] = r.rd; w[14:12] = r.f3;
        w[19:15] = r.rs1; w[31:20] = r.imm[11:0];
      end
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input req_t r);
    req_vld = 1'b1;
    kind = r.k; funct3 = r.f3; alt = r.alt;
    rd = r.rd; rs1 = r.rs1; rs2 = r.rs2; imm = r.imm;
  endtask

  task automatic test_reset();
    req_vld = 1'b0; instr_rdy = 1'b0;
    #2 rst = 1'b1;
    #2;
    checks++;
    if (instr_vld !== 1'b0 || instr !== 32'h0) begin
      failures++; $display("FAIL reset_queue: vld=%b instr=%h required vld=0 instr=0", instr_vld, instr);
    end
    checks++;
    if (illegal !== 1'b0 || count !== 16'h0 || count_w !== 2'd0) begin
      failures++; $display("FAIL reset_state: illegal=%b count=%0d count_w=%0d required 0/0/0", illegal, count, count_w);
    end
    tick();
    rst = 1'b0;
    exp_count = '0;
    tick();
    checks++;
    if (req_rdy !== 1'b1) begin
      failures++; $display("FAIL reset_rdy: req_rdy=%b required 1", req_rdy);
    end
  endtask

  // Spot encodings with known constant results, one request at a time
  task automatic test_basic();
    req_t        tbl[3];
    logic [31:0] cst[3];
    logic [31:0] e;
    tbl[0] = '{4'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0};  cst[0] = 32'h002081B3;
    tbl[1] = '{4'd1, 3'b101, 1'b1, 5'd5, 5'd6, 5'd0, 32'd7};  cst[1] = 32'h40735293;
    tbl[2] = '{4'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8};  cst[2] = 32'h00208463;
    instr_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(tbl[i]);
      exp_q.push_back(cst[i]);
      tick();
      req_vld = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (instr_vld !== 1'b1 || instr !== e || illegal !== 1'b0) begin
        failures++; $display("FAIL basic_word[%0d]: vld=%b instr=%h illegal=%b required vld=1 instr=%h illegal=0", i, instr_vld, instr, illegal, e);
      end
      tick();
      exp_count++;
      checks++;
      if (count !== exp_count || instr_vld !== 1'b0 || instr !== 32'h0) begin
        failures++; $display("FAIL basic_count[%0d]: count=%0d vld=%b instr=%h required count=%0d vld=0 instr=0", i, count, instr_vld, instr, exp_count);
      end
    end
  endtask

  // All formats streamed back-to-back with the consumer always ready
  task automatic test_formats();
    req_t        tbl[11];
    logic [31:0] e;
    tbl[0]  = '{4'd0, 3'b000, 1'b1, 5'd7,  5'd8,  5'd9,  32'd0};         // SUB
    tbl[1]  = '{4'd0, 3'b101, 1'b1, 5'd31, 5'd30, 5'd29, 32'd0};         // SRA
    tbl[2]  = '{4'd1, 3'b000, 1'b0, 5'd1,  5'd2,  5'd17, 32'hFFFFFFFB};  // ADDI -5
    tbl[3]  = '{4'd1, 3'b001, 1'b0, 5'd4,  5'd5,  5'd0,  32'h00000FFF};  // SLLI 31
    tbl[4]  = '{4'd2, 3'b010, 1'b0, 5'd9,  5'd11, 5'd10, 32'hFFFFFFFC};  // SW -4
    tbl[5]  = '{4'd3, 3'b010, 1'b0, 5'd12, 5'd13, 5'd21, 32'd2047};      // LW
    tbl[6]  = '{4'd4, 3'b001, 1'b0, 5'd6,  5'd3,  5'd4,  32'hFFFFF000};  // BNE -4096
    tbl[7]  = '{4'd5, 3'b000, 1'b0, 5'd14, 5'd7,  5'd8,  32'hABCDE123};  // LUI
    tbl[8]  = '{4'd6, 3'b000, 1'b0, 5'd15, 5'd1,  5'd1,  32'h12345FFF};  // AUIPC
    tbl[9]  = '{4'd7, 3'b000, 1'b0, 5'd1,  5'd19, 5'd20, 32'h0007A5A6};  // JAL
    tbl[10] = '{4'd8, 3'b000, 1'b0, 5'd2,  5'd3,  5'd22, 32'hFFFFF800};  // JALR
    instr_rdy = 1'b1;
    for (int i = 0; i <= 11; i++) begin
      if (instr_vld) begin
        e = exp_q.pop_front();
        checks++;
        if (instr !== e) begin
          failures++; $display("FAIL format_word[%0d]: instr=%h required %h", i - 1, instr, e);
        end
        exp_count++;
      end
      if (i < 11) begin
        checks++;
        if (req_rdy !== 1'b1) begin
          failures++; $display("FAIL format_rdy[%0d]: req_rdy=%b required 1", i, req_rdy);
        end
        drive(tbl[i]);
        exp_q.push_back(model(tbl[i]));
      end else begin
        req_vld = 1'b0;
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0 || instr_vld !== 1'b0 || count !== exp_count) begin
      failures++; $display("FAIL format_drain: left=%0d vld=%b count=%0d required left=0 vld=0 count=%0d", exp_q.size(), instr_vld, count, exp_count);
    end
  endtask

  // Back-pressure: fill queue, block third request, release in order
  task automatic test_back_to_back();
    req_t        tbl[3];
    logic [31:0] e;
    int          idx;
    tbl[0] = '{4'd1, 3'b100, 1'b0, 5'd10, 5'd11, 5'd0, 32'h00000555}; // XORI
    tbl[1] = '{4'd3, 3'b100, 1'b0, 5'd12, 5'd13, 5'd0, 32'hFFFFF801}; // LBU
    tbl[2] = '{4'd2, 3'b000, 1'b0, 5'd0,  5'd14, 5'd15, 32'd33};      // SB
    idx = 0;
    instr_rdy = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc == 3) instr_rdy = 1'b1;
      if (cyc == 2 || cyc == 3) begin
        checks++;
        if (instr_vld !== 1'b1 || instr !== exp_q[0] || req_rdy !== 1'b0) begin
          failures++; $display("FAIL b2b_full[%0d]: vld=%b instr=%h req_rdy=%b required vld=1 instr=%h req_rdy=0", cyc, instr_vld, instr, req_rdy, exp_q[0]);
        end
      end
      if (cyc == 4) begin
        checks++;
        if (req_rdy !== 1'b1 || idx != 2) begin
          failures++; $display("FAIL b2b_third: req_rdy=%b accepted=%0d required req_rdy=1 accepted=2", req_rdy, idx);
        end
      end
      if (instr_vld && instr_rdy) begin
        e = exp_q.pop_front();
        checks++;
        if (instr !== e) begin
          failures++; $display("FAIL b2b_order[%0d]: instr=%h required %h", cyc, instr, e);
        end
        exp_count++;
      end
      if (idx < 3) begin
        drive(tbl[idx]);
        if (req_rdy) begin
          exp_q.push_back(model(tbl[idx]));
          idx++;
        end
      end else begin
        req_vld = 1'b0;
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0 || idx != 3 || count !== exp_count) begin
      failures++; $display("FAIL b2b_drain: left=%0d accepted=%0d count=%0d required left=0 accepted=3 count=%0d", exp_q.size(), idx, count, exp_count);
    end
  endtask

  task automatic test_illegal();
    req_t tbl[9];
    tbl[0] = '{4'd7,  3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd3};  // JAL odd
    tbl[1] = '{4'd12, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0};  // kind 12
    tbl[2] = '{4'd2,  3'b011, 1'b0, 5'd0, 5'd2, 5'd3, 32'd0};  // S f3 011
    tbl[3] = '{4'd4,  3'b010, 1'b0, 5'd0, 5'd2, 5'd3, 32'd8};  // B f3 010
    tbl[4] = '{4'd4,  3'b000, 1'b0, 5'd0, 5'd2, 5'd3, 32'd5};  // B odd
    tbl[5] = '{4'd8,  3'b001, 1'b0, 5'd1, 5'd2, 5'd0, 32'd0};  // JALR f3 001
    tbl[6] = '{4'd0,  3'b001, 1'b1, 5'd1, 5'd2, 5'd3, 32'd0};  // R alt f3 001
    tbl[7] = '{4'd1,  3'b000, 1'b1, 5'd1, 5'd2, 5'd0, 32'd0};  // ADDI alt
    tbl[8] = '{4'd3,  3'b111, 1'b0, 5'd1, 5'd2, 5'd0, 32'd0};  // L f3 111
    instr_rdy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i]);
      tick();
      req_vld = 1'b0;
      checks++;
      if (illegal !== 1'b1 || instr_vld !== 1'b0) begin
        failures++; $display("FAIL illegal_pulse[%0d]: illegal=%b vld=%b required illegal=1 vld=0", i, illegal, instr_vld);
      end
      tick();
      checks++;
      if (illegal !== 1'b0 || instr_vld !== 1'b0 || count !== exp_count) begin
        failures++; $display("FAIL illegal_after[%0d]: illegal=%b vld=%b count=%0d required 0/0/%0d", i, illegal, instr_vld, count, exp_count);
      end
    end
  endtask

  task automatic test_count_wrap();
    req_t        r;
    logic [1:0]  seq[5];
    logic [31:0] e;
    seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0; seq[4] = 2'd1;
    rst = 1'b1;
    #2 rst = 1'b0;
    exp_count = '0;
    exp_q.delete();
    instr_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      r = '{4'd1, 3'b110, 1'b0, 5'd8, 5'd9, 5'd0, 32'(i * 3)};  // ORI
      drive(r);
      exp_q.push_back(model(r));
      tick();
      req_vld = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (instr_w !== e || instr !== e) begin
        failures++; $display("FAIL wrap_word[%0d]: instr=%h instr_w=%h required %h", i, instr, instr_w, e);
      end
      tick();
      exp_count++;
      checks++;
      if (count_w !== seq[i] || count !== exp_count) begin
        failures++; $display("FAIL wrap_count[%0d]: count_w=%0d count=%0d required %0d/%0d", i, count_w, count, seq[i], exp_count);
      end
    end
  endtask

  task automatic test_reset_mid();
    req_t r;
    instr_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      r = '{4'd5, 3'b000, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'h11111000};
      drive(r);
      tick();
    end
    req_vld = 1'b0;
    checks++;
    if (instr_vld !== 1'b1 || req_rdy !== 1'b0) begin
      failures++; $display("FAIL midreset_pre: vld=%b req_rdy=%b required vld=1 req_rdy=0", instr_vld, req_rdy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (instr_vld !== 1'b0 || instr !== 32'h0 || count !== 16'h0 || count_w !== 2'd0) begin
      failures++; $display("FAIL midreset_clear: vld=%b instr=%h count=%0d count_w=%0d required 0/0/0/0", instr_vld, instr, count, count_w);
    end
    #1 rst = 1'b0;
    exp_q.delete();
    exp_count = '0;
    instr_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (instr_vld !== 1'b0 || count !== 16'h0 || req_rdy !== 1'b1) begin
        failures++; $display("FAIL midreset_after[%0d]: vld=%b count=%0d req_rdy=%b required 0/0/1", i, instr_vld, count, req_rdy);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_formats();
    test_back_to_back();
    test_illegal();
    test_count_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
